// File: rtl/frame_buf_pkg.sv
// Shared definitions for the ping-pong frame buffer write path.
//   - FSM state encoding of the write controller (IDLE, FILL, STALL)
//   - bank index width (two banks -> one bit)
//   - assert/deassert level constants for single-bit strobes and flags
package frame_buf_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] FILL  = 2'd1;
    localparam logic [STATE_W-1:0] STALL = 2'd2;

    localparam int BANK_W = 1;

    localparam logic ASSERT   = 1'b1;
    localparam logic DEASSERT = 1'b0;

endpackage

// File: rtl/frame_bank_tracker.sv
// Tracks which of the two frame banks hold a completed frame and which one the
// display reader owns next.
//   wr_clk      clock
//   reset       synchronous, active-high
//   set_en      pulse: the bank in set_bank has received its final write
//   set_bank    bank being completed
//   rd_release  pulse: reader is finished with frame_bank
//   bank_full   per-bank completed flag (used by the writer to avoid full banks)
//   frame_rdy   at least one completed bank is waiting for the reader
//   frame_bank  oldest completed bank
//   rel_err     pulse: rd_release seen while nothing was ready
module frame_bank_tracker
    import frame_buf_pkg::*;
(
    input  logic              wr_clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [BANK_W-1:0] set_bank,
    input  logic              rd_release,
    output logic [1:0]        bank_full,
    output logic              frame_rdy,
    output logic [BANK_W-1:0] frame_bank,
    output logic              rel_err
);

    logic              release_ok;
    logic [BANK_W-1:0] rd_bank_reg;
    logic              rel_err_reg;

    // Release is only meaningful while a frame is actually handed out.
    assign release_ok = rd_release & (|bank_full);

    // A set and a clear in the same cycle always hit different banks, since the
    // writer never enters a full bank; each bank flag therefore sees at most one.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic full_reg;

            always_ff @(posedge wr_clk) begin
                if (reset) begin
                    full_reg <= DEASSERT;
                end else if (set_en && (set_bank == BANK_W'(gi))) begin
                    full_reg <= ASSERT;
                end else if (release_ok && (rd_bank_reg == BANK_W'(gi))) begin
                    full_reg <= DEASSERT;
                end
            end

            assign bank_full[gi] = full_reg;
        end
    endgenerate

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            rd_bank_reg <= '0;
            rel_err_reg <= DEASSERT;
        end else begin
            rel_err_reg <= rd_release & ~(|bank_full);
            if (release_ok) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    assign frame_rdy  = |bank_full;
    assign frame_bank = rd_bank_reg;
    assign rel_err    = rel_err_reg;

endmodule

// File: rtl/frame_buf_wr_ctrl.sv
// Write-side controller: drains a valid/ready pixel stream into a two-bank
// (ping-pong) frame memory and hands completed banks to the display reader.
//   wr_clk, reset          clock, synchronous active-high reset
//   pix_valid/pix_ready    pixel stream handshake (pix_ready depends on state only)
//   pix_data, pix_sof      pixel value, first-pixel-of-frame marker
//   mem_wr_en/addr/data    registered memory write port, addr = {bank, index}
//   frame_rdy, frame_bank  completed bank available to the reader, oldest first
//   rd_release             reader is done with frame_bank
//   sync_err               pulse: sof arrived in the middle of a frame
//   rel_err                pulse: rd_release arrived with nothing ready
module frame_buf_wr_ctrl
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_WIDTH   = 3,
    parameter int FRAME_PIXELS = 1 << ADDR_WIDTH
)
(
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_sof,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  frame_rdy,
    output logic                  frame_bank,
    input  logic                  rd_release,
    output logic                  sync_err,
    output logic                  rel_err
);

    // One extra counter bit so FRAME_PIXELS == 2^ADDR_WIDTH compares cleanly.
    localparam int              CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic [STATE_W-1:0]    state_reg, state_next;
    logic [CNT_W-1:0]      pix_cnt_reg, pix_cnt_next;
    logic [BANK_W-1:0]     wr_bank_reg, wr_bank_next;
    logic                  accept;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  last_pix;
    logic                  sync_next;

    logic                  wr_en_reg;
    logic [ADDR_WIDTH:0]   wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic                  sync_err_reg;
    logic                  done_reg;
    logic [BANK_W-1:0]     done_bank_reg;
    logic [1:0]            bank_full;

    assign pix_ready = ~reset & (state_reg != STALL);
    assign accept    = pix_valid & pix_ready;

    always_comb begin
        state_next   = state_reg;
        pix_cnt_next = pix_cnt_reg;
        wr_bank_next = wr_bank_reg;
        wr_fire      = DEASSERT;
        wr_idx       = '0;
        last_pix     = DEASSERT;
        sync_next    = DEASSERT;

        case (state_reg)
            IDLE: begin
                // Pixels outside a frame are dropped until a sof realigns us.
                if (accept && pix_sof) begin
                    wr_fire      = ASSERT;
                    pix_cnt_next = CNT_W'(1);
                    state_next   = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_fire = ASSERT;
                    if (pix_sof) begin
                        // Restart the frame in the same bank.
                        sync_next    = ASSERT;
                        pix_cnt_next = CNT_W'(1);
                    end else begin
                        wr_idx = pix_cnt_reg[ADDR_WIDTH-1:0];
                        if (pix_cnt_reg == LAST_IDX) begin
                            last_pix     = ASSERT;
                            pix_cnt_next = '0;
                            wr_bank_next = ~wr_bank_reg;
                            state_next   = bank_full[~wr_bank_reg] ? STALL : IDLE;
                        end else begin
                            pix_cnt_next = pix_cnt_reg + CNT_W'(1);
                        end
                    end
                end
            end
            STALL: begin
                if (!bank_full[wr_bank_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pix_cnt_reg   <= '0;
            wr_bank_reg   <= '0;
            wr_en_reg     <= DEASSERT;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            sync_err_reg  <= DEASSERT;
            done_reg      <= DEASSERT;
            done_bank_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pix_cnt_reg   <= pix_cnt_next;
            wr_bank_reg   <= wr_bank_next;
            wr_en_reg     <= wr_fire;
            sync_err_reg  <= sync_next;
            // Completion is flagged one cycle late so the bank only turns full
            // together with its final memory write.
            done_reg      <= last_pix;
            done_bank_reg <= wr_bank_reg;
            if (wr_fire) begin
                wr_addr_reg <= {wr_bank_reg, wr_idx};
                wr_data_reg <= pix_data;
            end
        end
    end

    assign mem_wr_en   = wr_en_reg;
    assign mem_wr_addr = wr_addr_reg;
    assign mem_wr_data = wr_data_reg;
    assign sync_err    = sync_err_reg;

    frame_bank_tracker u_tracker (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .set_en     (done_reg),
        .set_bank   (done_bank_reg),
        .rd_release (rd_release),
        .bank_full  (bank_full),
        .frame_rdy  (frame_rdy),
        .frame_bank (frame_bank),
        .rel_err    (rel_err)
    );

endmodule

// File: tb/tb_frame_buf_wr_ctrl.sv
// Directed bench for frame_buf_wr_ctrl with ADDR_WIDTH=3, FRAME_PIXELS=8.
module tb_frame_buf_wr_ctrl;

    logic        wr_clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr;
    logic [23:0] mem_wr_data;
    logic        frame_rdy;
    logic        frame_bank;
    logic        rd_release = 1'b0;
    logic        sync_err;
    logic        rel_err;

    int passed = 0;
    int total  = 0;

    frame_buf_wr_ctrl #(.DATA_WIDTH(24), .ADDR_WIDTH(3), .FRAME_PIXELS(8)) dut (
        .wr_clk      (wr_clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .frame_rdy   (frame_rdy),
        .frame_bank  (frame_bank),
        .rd_release  (rd_release),
        .sync_err    (sync_err),
        .rel_err     (rel_err)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Presents one cycle of inputs, lets the edge consume them, then samples.
    task automatic drive(input logic v, input logic s, input logic [23:0] d, input logic r);
        pix_valid  = v;
        pix_sof    = s;
        pix_data   = d;
        rd_release = r;
        tick();
        $display("txn t=%0t rst=%0b valid=%0b sof=%0b data=%h rel=%0b -> we=%0b addr=%0d wdata=%h rdy=%0b bank=%0b serr=%0b rerr=%0b pready=%0b",
                 $time, reset, v, s, d, r, mem_wr_en, mem_wr_addr, mem_wr_data,
                 frame_rdy, frame_bank, sync_err, rel_err, pix_ready);
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 24'hABCDEF, 1'b0);
        total++;
        if (pix_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", pix_ready);
        else passed++;
        total++;
        if (mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en);
        else passed++;
        reset = 1'b0;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, frame_rdy, frame_bank, sync_err, rel_err} !== 33'h0)
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h rdy=%b bank=%b serr=%b rerr=%b expected all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, frame_rdy, frame_bank, sync_err, rel_err);
        else passed++;
        total++;
        if (pix_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", pix_ready);
        else passed++;
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 24'(i + 1), 1'b0);
            total++;
            if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 4'(i), 24'(i + 1)})
                $display("FAIL frame1_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, i, i + 1);
            else passed++;
        end
        total++;
        if (frame_rdy !== 1'b0) $display("FAIL frame1_rdy_early: got %b expected 0", frame_rdy);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({mem_wr_en, frame_rdy, frame_bank, pix_ready} !== 4'b0101)
            $display("FAIL frame1_done: got we=%b rdy=%b bank=%b ready=%b expected we=0 rdy=1 bank=0 ready=1",
                     mem_wr_en, frame_rdy, frame_bank, pix_ready);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 24'(i + 1), 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 24'h100 + 24'(i), 1'b0);
            total++;
            if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 4'(8 + i), 24'h100 + 24'(i)})
                $display("FAIL frame2_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, 8 + i, 24'h100 + 24'(i));
            else passed++;
        end
        total++;
        if (pix_ready !== 1'b0) $display("FAIL stall_enter: got ready=%b expected 0", pix_ready);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({pix_ready, frame_rdy, frame_bank} !== 3'b010)
            $display("FAIL stall_hold: got ready=%b rdy=%b bank=%b expected ready=0 rdy=1 bank=0",
                     pix_ready, frame_rdy, frame_bank);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        total++;
        if ({pix_ready, frame_rdy, frame_bank} !== 3'b011)
            $display("FAIL stall_release: got ready=%b rdy=%b bank=%b expected ready=0 rdy=1 bank=1",
                     pix_ready, frame_rdy, frame_bank);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if (pix_ready !== 1'b1) $display("FAIL stall_exit: got ready=%b expected 1", pix_ready);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 24'h200 + 24'(i), 1'b0);
            total++;
            if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 4'(i), 24'h200 + 24'(i)})
                $display("FAIL frame3_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, i, 24'h200 + 24'(i));
            else passed++;
        end
    endtask

    task automatic test_no_sof_discard();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 24'hA0 + 24'(i), 1'b0);
            total++;
            if (mem_wr_en !== 1'b0) $display("FAIL idle_discard[%0d]: got we=%b expected 0", i, mem_wr_en);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 24'h10 + 24'(i), 1'b0);
            total++;
            if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 4'(i), 24'h10 + 24'(i)})
                $display("FAIL aligned_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, i, 24'h10 + 24'(i));
            else passed++;
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 24'h20 + 24'(i), 1'b0);
        drive(1'b1, 1'b1, 24'h55, 1'b0);
        total++;
        if ({sync_err, mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 1'b1, 4'd0, 24'h55})
            $display("FAIL resync_write: got serr=%b we=%b addr=%0d data=%h expected serr=1 we=1 addr=0 data=000055",
                     sync_err, mem_wr_en, mem_wr_addr, mem_wr_data);
        else passed++;
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 1'b0, 24'h60 + 24'(i), 1'b0);
            total++;
            if ({sync_err, mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b0, 1'b1, 4'(i), 24'h60 + 24'(i)})
                $display("FAIL resync_cont[%0d]: got serr=%b we=%b addr=%0d data=%h expected serr=0 we=1 addr=%0d data=%h",
                         i, sync_err, mem_wr_en, mem_wr_addr, mem_wr_data, i, 24'h60 + 24'(i));
            else passed++;
        end
        total++;
        if (frame_rdy !== 1'b0) $display("FAIL resync_rdy_early: got %b expected 0", frame_rdy);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({frame_rdy, frame_bank, sync_err} !== 3'b100)
            $display("FAIL resync_done: got rdy=%b bank=%b serr=%b expected rdy=1 bank=0 serr=0",
                     frame_rdy, frame_bank, sync_err);
        else passed++;
    endtask

    task automatic test_release();
        do_reset();
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        total++;
        if ({rel_err, frame_rdy, frame_bank, pix_ready} !== 4'b1001)
            $display("FAIL rel_err_pulse: got rerr=%b rdy=%b bank=%b ready=%b expected rerr=1 rdy=0 bank=0 ready=1",
                     rel_err, frame_rdy, frame_bank, pix_ready);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({rel_err, frame_bank} !== 2'b00)
            $display("FAIL rel_err_clear: got rerr=%b bank=%b expected rerr=0 bank=0", rel_err, frame_bank);
        else passed++;
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 24'h400 + 24'(i), 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 24'h500 + 24'(i), 1'b0);
        total++;
        if (pix_ready !== 1'b0) $display("FAIL release_stall: got ready=%b expected 0", pix_ready);
        else passed++;
        // Release lands in the same cycle bank 1 completes.
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        total++;
        if ({frame_rdy, frame_bank, rel_err} !== 3'b110)
            $display("FAIL release_overlap: got rdy=%b bank=%b rerr=%b expected rdy=1 bank=1 rerr=0",
                     frame_rdy, frame_bank, rel_err);
        else passed++;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({pix_ready, frame_rdy, frame_bank} !== 3'b111)
            $display("FAIL release_after: got ready=%b rdy=%b bank=%b expected ready=1 rdy=1 bank=1",
                     pix_ready, frame_rdy, frame_bank);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 24'h600 + 24'(i), 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if (frame_rdy !== 1'b1) $display("FAIL midreset_pre_rdy: got %b expected 1", frame_rdy);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, 24'h700 + 24'(i), 1'b0);
            total++;
            if ({mem_wr_en, mem_wr_addr} !== {1'b1, 4'(8 + i)})
                $display("FAIL midreset_frame2[%0d]: got we=%b addr=%0d expected we=1 addr=%0d",
                         i, mem_wr_en, mem_wr_addr, 8 + i);
            else passed++;
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 24'h704, 1'b0);
        total++;
        if ({mem_wr_en, pix_ready} !== 2'b00)
            $display("FAIL midreset_no_write: got we=%b ready=%b expected we=0 ready=0", mem_wr_en, pix_ready);
        else passed++;
        reset = 1'b0;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        total++;
        if ({mem_wr_en, frame_rdy, frame_bank, pix_ready} !== 4'b0001)
            $display("FAIL midreset_after: got we=%b rdy=%b bank=%b ready=%b expected we=0 rdy=0 bank=0 ready=1",
                     mem_wr_en, frame_rdy, frame_bank, pix_ready);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 24'h300 + 24'(i), 1'b0);
            total++;
            if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 4'(i), 24'h300 + 24'(i)})
                $display("FAIL midreset_next[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, i, 24'h300 + 24'(i));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_no_sof_discard();
        test_sync_err();
        test_release();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/frame_buf_wr_ctrl.md
Name: frame_buf_wr_ctrl

Overview:
Write-side controller that drains a valid/ready pixel stream into a two-bank (ping-pong) frame memory.
- Frames are aligned on pix_sof.
- Writes are issued as a registered memory write port.
- Completed banks are tracked and handed to the display reader via frame_rdy/frame_bank.
- The reader returns banks with rd_release.
- Sits between the pixel source and the dual-port frame memory. All logic is in the wr_clk domain; rd_release is synchronized to wr_clk outside this block.

Parameters:
DATA_WIDTH, 24, pixel width in bits
ADDR_WIDTH, 3, per-bank pixel address width
FRAME_PIXELS, 1 << ADDR_WIDTH, pixels per frame; must be >= 2 and <= 2^ADDR_WIDTH

Ports:
wr_clk  in  1  clock; all I/O synchronous to it
reset  in  1  synchronous, active-high
pix_valid  in  1  source has a pixel
pix_ready  out  1  block can accept a pixel
pix_data  in  DATA_WIDTH  pixel value
pix_sof  in  1  qualifies pix_data as first pixel of a frame
mem_wr_en  out  1  memory write strobe, active-high
mem_wr_addr  out  ADDR_WIDTH+1  {bank, pixel index}
mem_wr_data  out  DATA_WIDTH  write data
frame_rdy  out  1  at least one completed bank awaits the reader
frame_bank  out  1  oldest completed bank (valid while frame_rdy=1)
rd_release  in  1  1-cycle pulse: reader finished with frame_bank
sync_err  out  1  1-cycle pulse: sof arrived mid-frame
rel_err  out  1  1-cycle pulse: rd_release arrived while frame_rdy=0

Behaviour:
- Reset (synchronous, active-high, clock wr_clk):
  - state=IDLE; wr_bank=0; rd_bank=0; bank_full=2'b00; pix_cnt=0.
  - mem_wr_en, mem_wr_addr, mem_wr_data, frame_rdy, frame_bank, sync_err, rel_err all 0.
  - pix_ready=0 while reset is high.
  - Reset mid-frame discards the partial frame and any completed banks. No mem_wr_en in the cycle after reset.
- accept = pix_valid & pix_ready.
- pix_ready = 1 in IDLE and FILL, 0 in STALL. It is combinational from state only and never depends on pix_valid.
- State IDLE:
  - Accept with sof=0: pixel is discarded, no write.
  - Accept with sof=1: write index 0, pix_cnt<=1, go to FILL.
- State FILL, accept with sof=1:
  - sync_err pulses; restart the frame in the same bank.
  - Write index 0, pix_cnt<=1.
- State FILL, accept with sof=0:
  - Write index pix_cnt.
  - If pix_cnt==FRAME_PIXELS-1, this is the last pixel:
    - Mark the bank for completion and toggle wr_bank.
    - If bank_full[~old wr_bank]==1, go to STALL; otherwise go to IDLE.
  - Otherwise pix_cnt<=pix_cnt+1.
- State FILL, no accept: hold.
- State STALL: go to IDLE on the first cycle bank_full[wr_bank]==0.
- Write port latency, for an accept in cycle T:
  - Cycle T+1: mem_wr_en=1, mem_wr_addr={wr_bank at T, index}, mem_wr_data=pix_data at T.
  - mem_wr_en=0 in every cycle not following an accept that writes.
- Completion, for a last-pixel accept in cycle T:
  - bank_full[bank] is set at the end of T+1, after its final write.
  - frame_rdy=1 from T+2.
- frame_rdy = |bank_full. frame_bank = rd_bank. Both are registered state, no combinational input paths.
- rd_release with frame_rdy=1: clear bank_full[rd_bank], toggle rd_bank. frame_rdy/frame_bank update the next cycle.
- rd_release with frame_rdy=0: ignored; rel_err pulses next cycle.
- Completion set and release clear in the same cycle always target different banks. Both take effect.
- A frame never overwrites a full bank. The writer enters a bank only when it is free.
- pix_cnt width is ADDR_WIDTH+1 to allow FRAME_PIXELS = 2^ADDR_WIDTH without wrap ambiguity.

Decomposition:
- Shared package frame_buf_pkg:
  - state encoding (IDLE, FILL, STALL)
  - bank index width constant
  - assert/deassert level constants
- One sub-module, frame_bank_tracker, which owns:
  - bank_full[1:0] and rd_bank
  - the completion-set and release-clear logic
  - rel_err, frame_rdy, frame_bank
- The top level holds the FSM, pix_cnt, wr_bank and the write-port registers.

Test Plan (ADDR_WIDTH=3, FRAME_PIXELS=8):
1. Reset, then 8 accepts with sof on the first, data 1..8 -> mem_wr_en on 8 consecutive cycles, addr 0..7, data 1..8; frame_rdy=1 two cycles after the last accept with frame_bank=0; next frame writes addr 8..15.
2. Two full frames with no release -> after the 16th pixel, pix_ready=0 (STALL). Then rd_release -> frame_bank goes 0->1, pix_ready returns to 1 one cycle later, and the third frame writes addr 0..7.
3. 3 pixels without sof in IDLE, then a frame -> no writes for the first 3; writes start at addr 0 on the sof pixel.
4. sof at pixel index 5 -> sync_err pulses once; that pixel is written to addr 0, and the frame completes after 7 more pixels.
5. rd_release while frame_rdy=0 -> rel_err pulses one cycle, state unchanged. Release in the same cycle as frame-1 completion -> bank 0 freed, bank 1 full, frame_rdy stays 1, frame_bank=1.
6. reset asserted at pixel 4 of frame 2 with bank 0 full -> no mem_wr_en in the next cycle; frame_rdy=0 and pix_ready=1 after reset; the next frame writes bank 0.
